// File: rtl/data_cache_pkg.sv
// Shared types and address-field helpers for the data cache.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package data_cache_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2
  } cacheState_e;

  // Byte offset inside a 32-bit word; one word per line so this is the whole line offset.
  localparam int OFFSET_W = 2;

  function automatic int idxWidth(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tagWidth(input int addrWidth, input int sets);
    return addrWidth - $clog2(sets) - OFFSET_W;
  endfunction

endpackage

// File: rtl/data_cache_way.sv
// One way of the cache: valid bits, tag array and data array, one word per line.
// Latency: combinational lookup, write on the clock edge with wrEn.
// Backpressure: none; the parent decides when to write.
module cache_way
  import data_cache_pkg::*;
#(
  parameter int SETS       = 8,
  parameter int TAG_W      = 27,
  parameter int DATA_WIDTH = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      clear,
  input  logic [idxWidth(SETS)-1:0] idx,
  input  logic [TAG_W-1:0]          tag,
  output logic                      hit,
  output logic                      valid,
  output logic [DATA_WIDTH-1:0]     rdData,
  input  logic                      wrEn,
  input  logic [DATA_WIDTH-1:0]     wrData
);

  logic [SETS-1:0]       vld;
  logic [TAG_W-1:0]      tags [SETS];
  logic [DATA_WIDTH-1:0] data [SETS];

  assign valid  = vld[idx];
  assign hit    = vld[idx] && (tags[idx] == tag);
  assign rdData = data[idx];

  // Valid bits are the only reset state; a clear wipes the whole way.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld <= '0;
    end else if (clear) begin
      vld <= '0;
    end else if (wrEn) begin
      vld[idx] <= 1'b1;
    end
  end

  // Tag and data storage is never reset; validity alone qualifies it.
  always_ff @(posedge clk_i) begin
    if (wrEn) begin
      tags[idx] <= tag;
      data[idx] <= wrData;
    end
  end

endmodule

// File: rtl/data_cache.sv
// Write-through, no-write-allocate data cache, 1- or 2-way, one word per line.
// Latency: read hit same cycle; misses and stores stall until mem_ack_i.
// Backpressure: stall_o holds the pipeline; optional stats under DATA_CACHE_STATS_EN.
module data_cache
  import data_cache_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int SETS       = 8,
  parameter int WAYS       = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  stall_o,
  input  logic                  flush_i,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  input  logic                  mem_ack_i
`ifdef DATA_CACHE_STATS_EN
  ,
  output logic [31:0]           hit_cnt_o,
  output logic [31:0]           miss_cnt_o
`endif
);

  localparam int IDX_W = idxWidth(SETS);
  localparam int TAG_W = tagWidth(ADDR_WIDTH, SETS);

  cacheState_e           state;
  logic                  memReq, memWe, pendingFlush;
  logic [ADDR_WIDTH-1:0] memAddr;
  logic [DATA_WIDTH-1:0] memWdata;
  logic [SETS-1:0]       lru;   // per set: index of the least-recently-used way

  logic                  busy, flushNow, memAck;
  logic [ADDR_WIDTH-1:0] lookupAddr;
  logic [IDX_W-1:0]      idx;
  logic [TAG_W-1:0]      tag;
  logic [WAYS-1:0]       wayHit, wayValid, wayWe;
  logic [DATA_WIDTH-1:0] wayData [WAYS];
  logic [DATA_WIDTH-1:0] hitData, wrData;
  logic [1:0]            hitPad, vldPad;
  logic                  hitAny, hitWay, victim, idleHit, readHit, readMiss;

  // While busy the captured address drives lookup and writeback, not the live request.
  assign busy       = (state != IDLE);
  assign lookupAddr = busy ? memAddr : addr_i;
  assign idx        = lookupAddr[IDX_W+OFFSET_W-1:OFFSET_W];
  assign tag        = lookupAddr[ADDR_WIDTH-1:IDX_W+OFFSET_W];
  assign flushNow   = !busy && (flush_i || pendingFlush);
  assign memAck     = busy && mem_ack_i;
  assign wrData     = (state == FILL) ? mem_rdata_i : memWdata;

  for (genvar w = 0; w < WAYS; w++) begin : gWay
    assign wayWe[w] = memAck && (((state == FILL) && (int'(victim) == w)) ||
                                 ((state == WRITE) && wayHit[w]));
    cache_way #(.SETS(SETS), .TAG_W(TAG_W), .DATA_WIDTH(DATA_WIDTH)) uWay (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .clear  (flushNow),
      .idx    (idx),
      .tag    (tag),
      .hit    (wayHit[w]),
      .valid  (wayValid[w]),
      .rdData (wayData[w]),
      .wrEn   (wayWe[w]),
      .wrData (wrData)
    );
  end

  // Hit detection, hit-way data mux and victim choice (invalid way first, then LRU).
  always_comb begin
    hitPad           = '0;
    vldPad           = '0;
    hitPad[WAYS-1:0] = wayHit;
    vldPad[WAYS-1:0] = wayValid;
    hitAny           = |wayHit;
    hitWay           = hitPad[1];
    hitData          = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (wayHit[w]) hitData = wayData[w];
    end
    if (WAYS == 1)       victim = 1'b0;
    else if (!vldPad[0]) victim = 1'b0;
    else if (!vldPad[1]) victim = 1'b1;
    else                 victim = lru[idx];
  end

  // A flush in the same cycle turns the access into a miss.
  assign idleHit  = !busy && req_i && !flushNow && hitAny;
  assign readHit  = idleHit && !we_i;
  assign readMiss = !busy && req_i && !we_i && !idleHit;

  assign rdata_o     = readHit ? hitData : '0;
  assign stall_o     = rst_ni && (busy || (req_i && (we_i || !idleHit)));
  assign mem_req_o   = memReq;
  assign mem_we_o    = memWe;
  assign mem_addr_o  = memAddr;
  assign mem_wdata_o = memWdata;

  // Control FSM: captures the request, drives the memory handshake, tracks LRU and pending flush.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state        <= IDLE;
      memReq       <= 1'b0;
      memWe        <= 1'b0;
      memAddr      <= '0;
      memWdata     <= '0;
      pendingFlush <= 1'b0;
      lru          <= '0;
    end else begin
      case (state)
        IDLE: begin
          pendingFlush <= 1'b0;
          if (flushNow)     lru      <= '0;
          else if (readHit) lru[idx] <= ~hitWay;
          if (req_i && we_i) begin
            state    <= WRITE;
            memReq   <= 1'b1;
            memWe    <= 1'b1;
            memAddr  <= addr_i;
            memWdata <= wdata_i;
          end else if (readMiss) begin
            state   <= FILL;
            memReq  <= 1'b1;
            memWe   <= 1'b0;
            memAddr <= addr_i;
          end
        end
        FILL: begin
          if (flush_i) pendingFlush <= 1'b1;
          if (mem_ack_i) begin
            state    <= IDLE;
            memReq   <= 1'b0;
            lru[idx] <= ~victim;
          end
        end
        WRITE: begin
          if (flush_i) pendingFlush <= 1'b1;
          if (mem_ack_i) begin
            state  <= IDLE;
            memReq <= 1'b0;
            memWe  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DATA_CACHE_STATS_EN
  // Saturating read hit/miss counters, cleared by reset or flush.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
    end else if (flushNow) begin
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
    end else begin
      if (readHit && (hit_cnt_o != '1))   hit_cnt_o  <= hit_cnt_o + 32'd1;
      if (readMiss && (miss_cnt_o != '1)) miss_cnt_o <= miss_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_data_cache.sv
// Directed self-checking bench for data_cache (SETS=8, WAYS=2).
// Inputs change on the falling edge; outputs are sampled 1 ns later or 1 ns after the rising edge.
// Stats checks are compiled in only when DATA_CACHE_STATS_EN is defined.
module tb_data_cache;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic        req = 1'b0, we = 1'b0, flush = 1'b0, ack = 1'b0;
  logic [31:0] addr = '0, wdata = '0, memRdata = '0;
  logic [31:0] rdata, memAddr, memWdata;
  logic        stall, memReq, memWe;
`ifdef DATA_CACHE_STATS_EN
  logic [31:0] hitCnt, missCnt;
`endif
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  data_cache #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .SETS(8), .WAYS(2)) dut (
    .clk_i       (clk),
    .rst_ni      (rstN),
    .req_i       (req),
    .we_i        (we),
    .addr_i      (addr),
    .wdata_i     (wdata),
    .rdata_o     (rdata),
    .stall_o     (stall),
    .flush_i     (flush),
    .mem_req_o   (memReq),
    .mem_we_o    (memWe),
    .mem_addr_o  (memAddr),
    .mem_wdata_o (memWdata),
    .mem_rdata_i (memRdata),
    .mem_ack_i   (ack)
`ifdef DATA_CACHE_STATS_EN
    ,
    .hit_cnt_o   (hitCnt),
    .miss_cnt_o  (missCnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // One read request; on a miss the caller services the fill next.
  task automatic readAccess(input logic [31:0] a, input logic expHit, input logic [31:0] expData,
                            input string tag);
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = a;
    #1;
    check({tag, "_stall"}, 32'(stall), 32'(!expHit));
    check({tag, "_rdata"}, rdata, expHit ? expData : 32'h0);
    @(posedge clk); #1;
    req = 1'b0;
  endtask

  task automatic storeAccess(input logic [31:0] a, input logic [31:0] d, input string tag);
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = a; wdata = d;
    #1;
    check({tag, "_stall"}, 32'(stall), 32'd1);
    @(posedge clk); #1;
    req = 1'b0; we = 1'b0;
  endtask

  // Checks the outstanding memory request, holds it for extraCyc cycles, then acks.
  task automatic serviceMem(input logic expWe, input logic [31:0] expAddr, input logic [31:0] expWdata,
                            input logic [31:0] ackData, input int extraCyc, input string tag);
    @(negedge clk);
    check({tag, "_memreq"}, 32'(memReq), 32'd1);
    check({tag, "_memwe"}, 32'(memWe), 32'(expWe));
    check({tag, "_memaddr"}, memAddr, expAddr);
    check({tag, "_busystall"}, 32'(stall), 32'd1);
    if (expWe) check({tag, "_memwdata"}, memWdata, expWdata);
    for (int i = 0; i < extraCyc; i++) begin
      @(negedge clk);
      check({tag, "_memreqhold"}, 32'(memReq), 32'd1);
    end
    ack = 1'b1; memRdata = ackData;
    @(posedge clk); #1;
    ack = 1'b0; memRdata = '0;
    check({tag, "_memreqdone"}, 32'(memReq), 32'd0);
  endtask

  task automatic doFlush();
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  initial begin
    // Reset with a live request: every output must stay quiet.
    req = 1'b1; addr = 32'h100;
    #12;
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_memreq", 32'(memReq), 32'd0);
    check("rst_memwe", 32'(memWe), 32'd0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_memaddr", memAddr, 32'h0);
    check("rst_memwdata", memWdata, 32'h0);
    @(negedge clk);
    req = 1'b0; rstN = 1'b1;

    // Cold read miss, fill after three cycles, retried access hits.
    readAccess(32'h100, 1'b0, 32'h0, "cold");
    serviceMem(1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 2, "cold_fill");
    readAccess(32'h100, 1'b1, 32'hDEADBEEF, "cold_retry");

    // LRU replacement in set 0.
    doFlush();
    readAccess(32'h000, 1'b0, 32'h0, "lru_a");
    serviceMem(1'b0, 32'h000, 32'h0, 32'h11111111, 0, "lru_a_fill");
    readAccess(32'h000, 1'b1, 32'h11111111, "lru_a_hit");
    readAccess(32'h020, 1'b0, 32'h0, "lru_b");
    serviceMem(1'b0, 32'h020, 32'h0, 32'h22222222, 1, "lru_b_fill");
    readAccess(32'h020, 1'b1, 32'h22222222, "lru_b_hit");
    readAccess(32'h000, 1'b1, 32'h11111111, "lru_a_again");
    readAccess(32'h040, 1'b0, 32'h0, "lru_c");
    serviceMem(1'b0, 32'h040, 32'h0, 32'h44444444, 0, "lru_c_fill");
    readAccess(32'h040, 1'b1, 32'h44444444, "lru_c_hit");
    readAccess(32'h000, 1'b1, 32'h11111111, "lru_a_kept");
    readAccess(32'h020, 1'b0, 32'h0, "lru_b_evicted");
    serviceMem(1'b0, 32'h020, 32'h0, 32'h22222222, 0, "lru_b_refill");

    // Write-through store hit, then no-write-allocate store miss.
    doFlush();
    readAccess(32'h100, 1'b0, 32'h0, "st_prime");
    serviceMem(1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 0, "st_prime_fill");
    storeAccess(32'h100, 32'h55, "st_hit");
    serviceMem(1'b1, 32'h100, 32'h55, 32'h0, 2, "st_hit_mem");
    readAccess(32'h100, 1'b1, 32'h55, "st_hit_read");
    storeAccess(32'h200, 32'h77, "st_miss");
    serviceMem(1'b1, 32'h200, 32'h77, 32'h0, 0, "st_miss_mem");
    readAccess(32'h200, 1'b0, 32'h0, "st_miss_read");
    serviceMem(1'b0, 32'h200, 32'h0, 32'h99, 0, "st_miss_fill");
    readAccess(32'h100, 1'b1, 32'h55, "st_other_way");
    readAccess(32'h200, 1'b1, 32'h99, "st_filled");

    // An ack while idle does nothing.
    @(negedge clk);
    ack = 1'b1; memRdata = 32'hFFFFFFFF;
    @(posedge clk); #1;
    ack = 1'b0; memRdata = '0;
    check("idle_ack_memreq", 32'(memReq), 32'd0);
    readAccess(32'h100, 1'b1, 32'h55, "idle_ack_read");

    // Reset in the middle of a fill aborts it; a stale ack is ignored.
    readAccess(32'h300, 1'b0, 32'h0, "rstfill");
    @(negedge clk);
    check("rstfill_memreq_before", 32'(memReq), 32'd1);
    rstN = 1'b0;
    #1;
    check("rstfill_memreq", 32'(memReq), 32'd0);
    check("rstfill_stall", 32'(stall), 32'd0);
    check("rstfill_memaddr", memAddr, 32'h0);
    @(negedge clk);
    rstN = 1'b1; ack = 1'b1; memRdata = 32'hBAD0BAD0;
    @(posedge clk); #1;
    ack = 1'b0; memRdata = '0;
    check("rstfill_stale_ack", 32'(memReq), 32'd0);
    readAccess(32'h300, 1'b0, 32'h0, "rstfill_remiss");
    serviceMem(1'b0, 32'h300, 32'h0, 32'h33333333, 0, "rstfill_fill");
    readAccess(32'h300, 1'b1, 32'h33333333, "rstfill_hit");

    // Flush raised during a store is applied once the FSM is idle again.
    storeAccess(32'h300, 32'hABCD0123, "wflush");
    @(negedge clk);
    flush = 1'b1;
    check("wflush_memwe", 32'(memWe), 32'd1);
    @(posedge clk); #1;
    flush = 1'b0;
    serviceMem(1'b1, 32'h300, 32'hABCD0123, 32'h0, 1, "wflush_mem");
    readAccess(32'h300, 1'b0, 32'h0, "wflush_miss");
    serviceMem(1'b0, 32'h300, 32'h0, 32'h12345678, 0, "wflush_fill");
    readAccess(32'h300, 1'b1, 32'h12345678, "wflush_hit");

    // Flush together with a read of a cached line: treated as a miss.
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 32'h300; flush = 1'b1;
    #1;
    check("flushreq_stall", 32'(stall), 32'd1);
    check("flushreq_rdata", rdata, 32'h0);
    @(posedge clk); #1;
    req = 1'b0; flush = 1'b0;
    serviceMem(1'b0, 32'h300, 32'h0, 32'h0BADF00D, 0, "flushreq_fill");
    readAccess(32'h300, 1'b1, 32'h0BADF00D, "flushreq_hit");

`ifdef DATA_CACHE_STATS_EN
    doFlush();
    check("stats_clr_hit", hitCnt, 32'd0);
    check("stats_clr_miss", missCnt, 32'd0);
    readAccess(32'h400, 1'b0, 32'h0, "stats_m1");
    serviceMem(1'b0, 32'h400, 32'h0, 32'hA, 0, "stats_f1");
    readAccess(32'h400, 1'b1, 32'hA, "stats_h1");
    readAccess(32'h404, 1'b0, 32'h0, "stats_m2");
    serviceMem(1'b0, 32'h404, 32'h0, 32'hB, 0, "stats_f2");
    readAccess(32'h404, 1'b1, 32'hB, "stats_h2");
    readAccess(32'h400, 1'b1, 32'hA, "stats_h3");
    check("stats_hit", hitCnt, 32'd3);
    check("stats_miss", missCnt, 32'd2);
    doFlush();
    check("stats_flush_hit", hitCnt, 32'd0);
    check("stats_flush_miss", missCnt, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/data_cache.md
DATA_CACHE -- requirements
Module: data_cache

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, byte address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, word width; only 32 is supported.
REQ-003 SHALL have parameter SETS, default 8, number of sets; power of two, at least 2.
REQ-004 SHALL have parameter WAYS, default 2, associativity; 1 or 2 only.
REQ-005 SHALL have ports: clk_i in 1, the single clock; rst_ni in 1, reset, asynchronous and active-low.
REQ-006 SHALL have ports: req_i in 1, access valid; we_i in 1, store; addr_i in ADDR_WIDTH, word-aligned byte address; wdata_i in DATA_WIDTH, store data.
REQ-007 SHALL have ports: rdata_o out DATA_WIDTH, load data; stall_o out 1, pipeline must hold the M stage.
REQ-008 SHALL have ports: flush_i in 1, invalidate all lines.
REQ-009 SHALL have ports: mem_req_o out 1, mem_we_o out 1, mem_addr_o out ADDR_WIDTH, mem_wdata_o out DATA_WIDTH, mem_rdata_i in DATA_WIDTH, mem_ack_i in 1; this is the backing-memory handshake.

Function
REQ-010 SHALL split addr_i into offset [1:0] (ignored), index [log2(SETS)+1:2] and tag (the remaining upper bits); one word per line.
REQ-011 SHALL use an FSM with states IDLE, FILL and WRITE.
REQ-012 Read hit in IDLE SHALL drive rdata_o combinationally in the same cycle, with stall_o=0.
REQ-013 A read hit SHALL mark the hit way most-recently-used.
REQ-014 Read miss in IDLE SHALL assert stall_o combinationally and move the FSM to FILL on the next edge.
REQ-015 In FILL, the block SHALL hold mem_req_o=1, mem_we_o=0 and mem_addr_o equal to the captured address until mem_ack_i=1.
REQ-016 On the ack edge, the block SHALL write mem_rdata_i into the victim way, set its valid bit, update LRU and return to IDLE.
REQ-017 After a fill, the retried access SHALL hit.
REQ-018 Victim selection: an invalid way first (way 0 before way 1), otherwise the LRU way; with WAYS=1, always way 0.
REQ-019 Store in IDLE SHALL be write-through and no-write-allocate.
REQ-020 A store SHALL assert stall_o and move to WRITE, holding mem_req_o=1, mem_we_o=1 and the captured address and data until mem_ack_i.
REQ-021 On a store hit, the cache word SHALL be updated on the ack edge; a store miss SHALL leave the cache unchanged.
REQ-022 stall_o SHALL equal 1 in FILL and WRITE, and in IDLE on a read miss or any store; otherwise 0.
REQ-023 req_i SHALL be ignored while the FSM is not IDLE; the captured request is authoritative.
REQ-024 mem_ack_i SHALL be ignored in IDLE.
REQ-025 A mem_ack_i asserted in the same cycle the request is issued SHALL not be possible; the request appears one cycle after the miss is detected.
REQ-026 flush_i in IDLE SHALL clear all valid and LRU bits on the next edge and take priority over a simultaneous req_i; that access is treated as a miss.
REQ-027 flush_i while busy SHALL be latched as pending and applied on the cycle the FSM returns to IDLE.
REQ-028 rdata_o SHALL be 0 when there is no hit.

Reset
REQ-029 rst_ni low SHALL asynchronously clear all valid bits, LRU bits and pending flush, and force the FSM to IDLE.
REQ-030 During reset, mem_req_o, mem_we_o, stall_o and rdata_o SHALL be 0, and mem_addr_o and mem_wdata_o SHALL be 0.
REQ-031 Reset during FILL or WRITE SHALL abort the transaction immediately; a later stale mem_ack_i SHALL be ignored.
REQ-032 Data and tag arrays SHALL not be reset.

Configuration
REQ-033 With DATA_CACHE_STATS_EN defined, the block SHALL add outputs hit_cnt_o and miss_cnt_o (32 bits each), counting read hits and read misses and saturating at all-ones; reset and flush_i SHALL clear them.
REQ-034 Without DATA_CACHE_STATS_EN, those ports and counters SHALL be absent.

Structure
REQ-035 A shared package SHALL hold the FSM state enum (IDLE/FILL/WRITE) and the address-field width helper constants.
REQ-036 One sub-module, cache_way, SHALL implement the tag/valid/data storage for a single way; it SHALL be instantiated WAYS times.

Verification
REQ-037 Cold read 0x100 -> stall_o=1, mem_req_o at 0x100; ack with 0xDEADBEEF after 3 cycles -> retry hits, rdata_o=0xDEADBEEF, stall_o=0.
REQ-038 SETS=8, WAYS=2: read 0x000, 0x020, then 0x000 (hits), then 0x040 -> the 0x020 line is evicted and 0x000 still hits.
REQ-039 Store 0x55 to cached 0x100 -> mem_we_o=1 until ack, then a read of 0x100 hits with 0x55; a store to uncached 0x200 followed by a read of 0x200 -> miss.
REQ-040 rst_ni low for 1 cycle mid-FILL -> mem_req_o=0 immediately; a stale ack is ignored and the next read of the same address misses.
REQ-041 flush_i asserted during WRITE -> applied on return to IDLE; a following read of a previously cached address misses.
REQ-042 DATA_CACHE_STATS_EN defined: 3 hits and 2 misses -> hit_cnt_o=3 and miss_cnt_o=2; after flush_i, both are 0.
